// File: rtl/wbm_rr_arbiter.sv
// Round-robin Wishbone master arbiter: N masters share one slave port, grant locked while the owner holds cyc.
// Optional strobe watchdog with ABORT state when WBM_ARB_TIMEOUT_EN is defined.
module wbm_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 32,
  parameter int unsigned TIMEOUT     = 255,
  localparam int unsigned SW         = DW / 8,
  localparam int unsigned IDW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [SW*NUM_MASTERS-1:0] wbm_sel_i,
  input  logic [AW*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [DW*NUM_MASTERS-1:0] wbm_dat_i,
  output logic [DW-1:0]             wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  input  logic [NUM_MASTERS-1:0]    wbm_mask,
  output logic [IDW-1:0]            wbm_id,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic                      wbs_we_o,
  output logic [SW-1:0]             wbs_sel_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
`ifdef WBM_ARB_TIMEOUT_EN
  localparam logic [1:0] S_ABORT  = 2'd2;
`endif

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [NUM_MASTERS-1:0] req;
  logic [IDW-1:0] pick;
  logic           tmo_err;
  logic           active;

  // Per-master views of the flattened payload buses
  logic [SW-1:0] sel_a [NUM_MASTERS];
  logic [AW-1:0] adr_a [NUM_MASTERS];
  logic [DW-1:0] dat_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
    assign sel_a[g] = wbm_sel_i[g*SW +: SW];
    assign adr_a[g] = wbm_adr_i[g*AW +: AW];
    assign dat_a[g] = wbm_dat_i[g*DW +: DW];
  end

  assign req    = wbm_cyc_i & wbm_stb_i & wbm_mask;
  assign active = (state_q == S_ACTIVE);

  // First requester at or after last_grant+1, wrapping
  always_comb begin
    logic [IDW-1:0] cand;
    logic           found;
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDW'((32'(last_q) + i) % NUM_MASTERS);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign wbs_cyc_o = active;
  assign wbs_stb_o = active & wbm_stb_i[id_q];
  assign wbs_we_o  = wbm_we_i[id_q];
  assign wbs_sel_o = sel_a[id_q];
  assign wbs_adr_o = adr_a[id_q];
  assign wbs_dat_o = dat_a[id_q];
  assign wbm_dat_o = wbs_dat_i;
  assign wbm_id    = id_q;

  // Terminations reach only the owner; suppressed while reset is being applied
  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (active && wb_rst_i) begin
      wbm_ack_o[id_q] = wbs_ack_i;
      wbm_err_o[id_q] = wbs_err_i | tmo_err;
    end
  end

`ifdef WBM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Slave ack in the expiry cycle takes precedence over the watchdog
  assign tmo_err = active & wbm_cyc_i[id_q] & wbm_stb_i[id_q] &
                   (cnt_q == CW'(TIMEOUT)) & ~wbs_ack_i;

  always_comb begin
    cnt_d = '0;
    if (wbs_stb_o && !wbs_ack_i && !wbs_err_i)
      cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign tmo_err        = 1'b0;
  assign unused_timeout = ^16'(TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ACTIVE;
          id_d    = pick;
        end
      end
      S_ACTIVE: begin
        if (!wbm_cyc_i[id_q]) begin
          state_d = S_IDLE;
          last_d  = id_q;
        end else if (tmo_err) begin
`ifdef WBM_ARB_TIMEOUT_EN
          state_d = S_ABORT;
`endif
        end
      end
`ifdef WBM_ARB_TIMEOUT_EN
      S_ABORT: begin
        if (!wbm_cyc_i[id_q]) begin
          state_d = S_IDLE;
          last_d  = id_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      last_q  <= IDW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Self-checking bench for wbm_rr_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Follows WBM_ARB_TIMEOUT_EN the same way the design does.
module tb_wbm_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int SW  = 2;
  localparam int IDW = 2;
  localparam int TMO = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      cyc, stb, we, mask;
  logic [SW*N-1:0]   sel;
  logic [AW*N-1:0]   adr;
  logic [DW*N-1:0]   wdat;
  logic [DW-1:0]     sdat;
  logic              ack_i, err_i;

  logic [DW-1:0]     wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o;
  logic [IDW-1:0]    wbm_id;
  logic              wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [SW-1:0]     wbs_sel_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;

  wbm_rr_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we),
    .wbm_sel_i(sel), .wbm_adr_i(adr), .wbm_dat_i(wdat),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_mask(mask), .wbm_id(wbm_id),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(sdat), .wbs_ack_i(ack_i), .wbs_err_i(err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: who owns the slave (-1 = nobody), whether that ownership was aborted,
  // who was served last, the reported id, and how long the current strobe has stalled.
  int m_owner, m_last, m_id, m_cnt;
  bit m_abort;
  int grants[$];
  logic [N-1:0] obs_ack, obs_err, last_ack;
  logic         obs_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_stb();
    if (m_owner >= 0 && !m_abort) return stb[m_owner];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_abort = 1'b0; m_last = N - 1; m_id = 0; m_cnt = 0;
  endtask

  // Inputs are already applied at the falling edge; check, advance the model, move to next falling edge.
  task automatic step();
    bit active, tout;
    logic [N-1:0] r, e_ack, e_err;
    #1;
    active = (m_owner >= 0) && !m_abort;
    tout   = 1'b0;
`ifdef WBM_ARB_TIMEOUT_EN
    if (active) tout = cyc[m_owner] && stb[m_owner] && (m_cnt >= TMO) && !ack_i;
`endif
    e_ack = '0;
    e_err = '0;
    if (active && rst_n) begin
      e_ack[m_owner] = ack_i;
      e_err[m_owner] = err_i | tout;
    end
    chk("cyc_o", 64'(wbs_cyc_o), 64'(active));
    chk("id", 64'(wbm_id), 64'(m_id));
    chk("ack_o", 64'(wbm_ack_o), 64'(e_ack));
    chk("err_o", 64'(wbm_err_o), 64'(e_err));
    chk("stb_o", 64'(wbs_stb_o), 64'(active ? stb[m_owner] : 1'b0));
    chk("dat_bcast", 64'(wbm_dat_o), 64'(sdat));
    if (active) begin
      chk("adr_o", 64'(wbs_adr_o), 64'(adr[m_owner*AW +: AW]));
      chk("wdat_o", 64'(wbs_dat_o), 64'(wdat[m_owner*DW +: DW]));
      chk("we_o", 64'(wbs_we_o), 64'(we[m_owner]));
    end
    obs_ack  = wbm_ack_o;
    obs_err  = wbm_err_o;
    obs_cyc  = wbs_cyc_o;
    last_ack = e_ack;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      r = cyc & stb & mask;
      if (r != '0) begin
        m_owner = rr_pick(m_last, r);
        m_id    = m_owner;
        m_cnt   = 0;
        grants.push_back(m_owner);
      end
    end else if (!cyc[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_abort = 1'b0;
    end else if (!m_abort) begin
      if (tout) m_abort = 1'b1;
      else if (stb[m_owner] && !ack_i && !err_i) m_cnt = (m_cnt < TMO) ? m_cnt + 1 : m_cnt;
      else m_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_masters(input int n);
    cyc = '0; stb = '0; ack_i = 1'b0; err_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hi;
    rst_n = 1'b0; cyc = '0; stb = '0; we = '0; mask = 4'hF;
    sel = '0; ack_i = 1'b0; err_i = 1'b0; sdat = 16'h5A5A;
    adr = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    wdat = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
    last_ack = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    apply_reset();
    chk("rst_id", 64'(wbm_id), 64'd0);
    chk("rst_cyc", 64'(wbs_cyc_o), 64'd0);

    // Masters 1 and 3 request after reset: master 1 wins, cyc one cycle later
    cyc = 4'b1010; stb = 4'b1010;
    #1 chk("lat_cyc_before", 64'(wbs_cyc_o), 64'd0);
    step();
    chk("first_grant_cyc", 64'(wbs_cyc_o), 64'd1);
    chk("first_grant_id", 64'(wbm_id), 64'd1);
    ack_i = model_stb();
    step();
    chk("first_ack", 64'(obs_ack), 64'b0010);
    idle_masters(2);

    // All masters request continuously with single-strobe cycles
    apply_reset();
    grants.delete();
    last_ack = '0;
    for (int i = 0; i < 20; i++) begin
      cyc = ~last_ack; stb = cyc;
      ack_i = model_stb();
      step();
    end
    for (int i = 0; i < 5; i++) begin
      int exp_g;
      exp_g = i % N;
      chk("rr_order", 64'(grants[i]), 64'(exp_g));
    end
    idle_masters(3);

    // Master 2 keeps cyc over three strobes while master 0 waits
    cyc = 4'b0100; stb = 4'b0100;
    step();
    cyc = 4'b0101; stb = 4'b0101;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      ack_i = model_stb();
      step();
      if (obs_ack[2]) cnt++;
    end
    chk("burst_acks_m2", 64'(cnt), 64'd3);
    cyc = 4'b0001; stb = 4'b0001; ack_i = 1'b0;
    step();
    step();
    chk("after_burst_id", 64'(wbm_id), 64'd0);
    chk("after_burst_cyc", 64'(wbs_cyc_o), 64'd1);
    idle_masters(2);

    // Masked master 3 is never granted until its mask bit returns
    mask = 4'b0111; cyc = 4'b1000; stb = 4'b1000;
    for (int i = 0; i < 3; i++) step();
    chk("masked_no_grant", 64'(wbs_cyc_o), 64'd0);
    mask = 4'hF;
    step();
    chk("unmask_cyc", 64'(wbs_cyc_o), 64'd1);
    chk("unmask_id", 64'(wbm_id), 64'd3);
    // Dropping the owner's mask does not break the grant
    mask = 4'b0111;
    step();
    chk("mask_drop_keeps", 64'(wbs_cyc_o), 64'd1);
    mask = 4'hF;
    idle_masters(2);

    // Slave never answers
    cyc = 4'b0001; stb = 4'b0001; ack_i = 1'b0;
    cnt = 0; hi = 0;
`ifdef WBM_ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_err[0]) cnt++;
    end
    chk("timeout_err_pulses", 64'(cnt), 64'd1);
    chk("abort_cyc_low", 64'(wbs_cyc_o), 64'd0);
`else
    for (int i = 0; i < 110; i++) begin
      step();
      if (obs_cyc) hi++;
    end
    chk("no_timeout_cyc_held", 64'(hi >= 100), 64'd1);
`endif
    idle_masters(2);

    // Reset in the middle of an owned cycle
    cyc = 4'b0010; stb = 4'b0010;
    step();
    step();
    rst_n = 1'b0; ack_i = 1'b1; err_i = 1'b1;
    step();
    chk("rst_mid_ack", 64'(obs_ack), 64'd0);
    chk("rst_mid_err", 64'(obs_err), 64'd0);
    chk("rst_mid_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("rst_mid_id", 64'(wbm_id), 64'd0);
    rst_n = 1'b1;
    idle_masters(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      cyc   = cyc ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      stb   = 4'($urandom);
      we    = 4'($urandom);
      sel   = 8'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      adr   = {$urandom, $urandom, $urandom, $urandom};
      wdat  = {$urandom, $urandom};
      sdat  = 16'($urandom);
      ack_i = ($urandom_range(0, 3) == 0);
      err_i = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wbm_rr_arbiter.md
WBM_RR_ARBITER -- requirements
Module: wbm_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter DW, default 16, data width (multiple of 8); SW = DW/8 select bits.
REQ-003 SHALL have parameter AW, default 32, address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles a strobe may wait for ack/err (1..65535).
REQ-005 SHALL have localparam IDW = ceil(log2(NUM_MASTERS)), minimum 1.
REQ-006 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-007 wb_rst_i  in  1  synchronous, active-low reset.
REQ-008 wbm_cyc_i, wbm_stb_i, wbm_we_i  in  NUM_MASTERS each  per-master cycle, strobe and write-enable.
REQ-009 wbm_sel_i  in  SW*NUM_MASTERS; wbm_adr_i  in  AW*NUM_MASTERS; wbm_dat_i  in  DW*NUM_MASTERS; master m uses slice m.
REQ-010 wbm_dat_o  out  DW  read data, broadcast to all masters.
REQ-011 wbm_ack_o, wbm_err_o  out  NUM_MASTERS  per-master termination.
REQ-012 wbm_mask  in  NUM_MASTERS  1 = master eligible for a new grant.
REQ-013 wbm_id  out  IDW  index of granted master.
REQ-014 wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1; wbs_sel_o  out  SW; wbs_adr_o  out  AW; wbs_dat_o  out  DW.
REQ-015 wbs_dat_i  in  DW; wbs_ack_i, wbs_err_i  in  1.

Function
REQ-016 SHALL implement states IDLE, ACTIVE, ABORT.
REQ-017 Request r[m] = wbm_cyc_i[m] & wbm_stb_i[m] & wbm_mask[m].
REQ-018 IDLE: if any r set, SHALL grant the first requesting index searching upward from (last_grant+1) mod NUM_MASTERS, wrapping; set wbm_id, go ACTIVE; wbs_cyc_o high the following cycle (1-cycle latency).
REQ-019 ACTIVE: wbs_cyc_o=1; wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o SHALL combinationally follow the granted master's slice.
REQ-020 ACTIVE: wbs_ack_i/wbs_err_i SHALL route combinationally only to granted master; all other ack/err bits 0.
REQ-021 Grant SHALL be held across multiple strobes while granted master keeps cyc high (burst/RMW lock).
REQ-022 ACTIVE: granted wbm_cyc_i sampled low -> IDLE next cycle, wbs_cyc_o low, last_grant <= wbm_id.
REQ-023 Deasserting wbm_mask of granted master SHALL NOT break current grant.
REQ-024 Timeout counter SHALL count cycles with wbs_stb_o=1 and no ack/err; clear on ack, err or stb low; saturating width ceil(log2(TIMEOUT+1)).
REQ-025 Counter reaching TIMEOUT SHALL pulse wbm_err_o[granted] one cycle, drop wbs_cyc_o/wbs_stb_o next cycle, go ABORT.
REQ-026 ABORT: wbs_cyc_o=0; wait for granted cyc low, then IDLE with last_grant update.
REQ-027 Simultaneous slave ack and timeout expiry: ack SHALL win, no err.
REQ-028 wbm_dat_o SHALL equal wbs_dat_i at all times.
REQ-029 In IDLE/ABORT wbs_stb_o=0 and all wbm_ack_o/wbm_err_o=0.

Reset
REQ-030 wb_rst_i low at an edge SHALL force IDLE, wbs_cyc_o=0, counter=0, wbm_id=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), regardless of state.
REQ-031 Reset mid-transaction SHALL drop wbs_cyc_o on that edge without issuing ack/err.

Configuration
REQ-032 Macro WBM_ARB_TIMEOUT_EN defined: REQ-024..027 and ABORT state present.
REQ-033 Macro undefined: no counter, no ABORT; ACTIVE waits indefinitely; TIMEOUT ignored.

Verification
REQ-034 Reset, then wbm_cyc_i=wbm_stb_i=4'b1010, mask=4'hF -> master 1 granted, wbs_cyc_o high 1 cycle after request, wbm_id=1.
REQ-035 All 4 masters request continuously, single-strobe cycles each -> grant order 0,1,2,3,0 with no cycle to a non-requester.
REQ-036 Master 2 holds cyc for 3 strobes while master 0 requests -> 3 acks to master 2, then master 0 granted.
REQ-037 TIMEOUT=8, slave never acks (macro defined) -> wbm_err_o[m] single pulse after 8 strobe cycles, wbs_cyc_o low next cycle; without macro -> cyc stays high 100+ cycles.
REQ-038 wbm_mask=4'b0111, master 3 requesting alone -> no grant; mask bit 3 set -> granted next cycle.
REQ-039 Reset asserted during ACTIVE -> wbs_cyc_o=0 next cycle, no ack/err to any master, wbm_id=0.
